uart_cmd_decoder: RTL and testbench



---
 rtl/uart_cmd_pkg.sv | 24 ++
 rtl/uart_cmd_decoder_dec_accum.sv | 68 ++++++
 rtl/uart_cmd_decoder.sv | 192 +++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command decoder:
//   - ASCII constants used by the command grammar (CR, LF, '0', '9')
//   - decoder state type (IDLE, FREQ)
//   - is_digit() helper for recognising decimal digit bytes
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_0  = 8'h30;
  localparam logic [7:0] CHR_9  = 8'h39;

  typedef enum logic {
    IDLE = 1'b0,
    FREQ = 1'b1
  } state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CHR_0) && (b <= CHR_9);
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_dec_accum.sv
// ---------------------------------------------------------------------------
// dec_accum
// Decimal digit accumulator for the frequency command.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : zero the accumulator and digit count
//   load        : fold 'digit' into the accumulator (acc = acc*10 + digit)
//   digit       : binary value of the incoming decimal digit (0..9)
//   acc         : current accumulated value
//   count       : number of digits accepted so far
//   overflow    : loading 'digit' now would exceed 2^FREQ_W-1
//   too_many    : MAX_DIGITS already accepted; one more would exceed the limit
// Both flags look ahead at the pending digit so the caller can reject it
// before it is ever loaded.
// ---------------------------------------------------------------------------
module dec_accum #(
  parameter int FREQ_W     = 16,
  parameter int MAX_DIGITS = 5,
  parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [3:0]        digit,
  output logic [FREQ_W-1:0] acc,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              too_many
);

  // acc*10 + 9 always fits in four extra bits
  localparam int WIDE_W = FREQ_W + 4;

  logic [FREQ_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [WIDE_W-1:0] wide_sum;

  assign wide_sum = ({4'd0, acc_reg} * WIDE_W'(10)) + WIDE_W'(digit);
  assign overflow = |wide_sum[WIDE_W-1:FREQ_W];
  assign too_many = (cnt_reg == CNT_W'(MAX_DIGITS));

  always_comb begin
    acc_next = acc_reg;
    cnt_next = cnt_reg;
    if (clr) begin
      acc_next = '0;
      cnt_next = '0;
    end else if (load) begin
      acc_next = wide_sum[FREQ_W-1:0];
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_next;
    end
  end

  assign acc   = acc_reg;
  assign count = cnt_reg;

endmodule

// File: rtl/uart_cmd_decoder.sv
// ---------------------------------------------------------------------------
// uart_cmd_decoder
// Decodes received UART bytes into
//   - single-letter mode commands (BASE_CHAR+k selects one-hot mode k)
//   - frequency commands: FREQ_CHAR, 1..MAX_DIGITS decimal digits, CR
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   rx_valid     : one-cycle strobe, rx_data holds a new byte
//   rx_data      : received byte
//   mode         : one-hot mode select (registered)
//   freq_word    : current frequency word (registered)
//   freq_update  : one-cycle pulse when freq_word is loaded
//   cmd_err      : one-cycle pulse on a malformed frequency command
//   busy         : high while a frequency command is in progress
// Optional build macro CMD_TIMEOUT_EN: abort a frequency command with
// cmd_err after TIMEOUT_CYCLES cycles without a received byte.
// ---------------------------------------------------------------------------
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int                NUM_MODES      = 2,
  parameter int                DEFAULT_MODE   = 0,
  parameter logic [7:0]        BASE_CHAR      = 8'h41,
  parameter logic [7:0]        FREQ_CHAR      = 8'h46,
  parameter int                FREQ_W         = 16,
  parameter logic [FREQ_W-1:0] FREQ_DEFAULT   = FREQ_W'(1000),
  parameter int                MAX_DIGITS     = 5,
  parameter int                TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic [NUM_MODES-1:0] mode,
  output logic [FREQ_W-1:0]    freq_word,
  output logic                 freq_update,
  output logic                 cmd_err,
  output logic                 busy
);

  localparam int                   CNT_W    = $clog2(MAX_DIGITS + 1);
  localparam logic [NUM_MODES-1:0] MODE_RST = NUM_MODES'(1) << DEFAULT_MODE;

  // Elaboration-time parameter checks
  if (NUM_MODES < 1 || NUM_MODES > 5) begin : g_bad_num_modes
    $error("uart_cmd_decoder: NUM_MODES must be in 1..5");
  end
  if (DEFAULT_MODE < 0 || DEFAULT_MODE >= NUM_MODES) begin : g_bad_default_mode
    $error("uart_cmd_decoder: DEFAULT_MODE must be < NUM_MODES");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_cmd_decoder: TIMEOUT_CYCLES must be >= 1");
  end

  state_t                state_reg, state_next;
  logic [NUM_MODES-1:0]  mode_reg, mode_next;
  logic [FREQ_W-1:0]     freq_word_reg, freq_word_next;
  logic                  freq_update_reg, freq_update_next;
  logic                  cmd_err_reg, cmd_err_next;
  logic                  busy_reg;

  logic                  acc_clr, acc_load, acc_ovf, acc_full;
  logic [FREQ_W-1:0]     acc_val;
  logic [CNT_W-1:0]      acc_cnt;
  logic                  byte_ok;
  logic                  tmo_expire;

  // Per-mode letter match; at most one bit can be set, so the vector
  // itself is the new one-hot mode value.
  logic [NUM_MODES-1:0]  mode_hit;
  genvar gi;
  generate
    for (gi = 0; gi < NUM_MODES; gi++) begin : g_mode_hit
      assign mode_hit[gi] = (rx_data == 8'(BASE_CHAR + gi));
    end
  endgenerate

  // LF is transparent in every state
  assign byte_ok = rx_valid && (rx_data != CHR_LF);

  dec_accum #(
    .FREQ_W     (FREQ_W),
    .MAX_DIGITS (MAX_DIGITS),
    .CNT_W      (CNT_W)
  ) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (acc_clr),
    .load     (acc_load),
    .digit    (rx_data[3:0]),
    .acc      (acc_val),
    .count    (acc_cnt),
    .overflow (acc_ovf),
    .too_many (acc_full)
  );

`ifdef CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;

  // Counts idle cycles in FREQ; any received byte (LF included) reloads it.
  always_comb begin
    tmo_cnt_next = '0;
    if (state_reg == FREQ && !rx_valid) begin
      tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
    end
  end

  // A byte in the expiry cycle wins, hence the !rx_valid term.
  assign tmo_expire = (state_reg == FREQ) && !rx_valid &&
                      (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_next;
    end
  end
`else
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    state_next       = state_reg;
    mode_next        = mode_reg;
    freq_word_next   = freq_word_reg;
    freq_update_next = 1'b0;
    cmd_err_next     = 1'b0;
    acc_clr          = 1'b0;
    acc_load         = 1'b0;
    if (byte_ok) begin
      case (state_reg)
        IDLE: begin
          if (|mode_hit) begin
            mode_next = mode_hit;
          end else if (rx_data == FREQ_CHAR) begin
            acc_clr    = 1'b1;
            state_next = FREQ;
          end
        end
        FREQ: begin
          if (is_digit(rx_data)) begin
            if (acc_ovf || acc_full) begin
              cmd_err_next = 1'b1;
              state_next   = IDLE;
            end else begin
              acc_load = 1'b1;
            end
          end else if (rx_data == CHR_CR && acc_cnt != '0) begin
            freq_word_next   = acc_val;
            freq_update_next = 1'b1;
            state_next       = IDLE;
          end else begin
            // Empty CR or any foreign byte aborts; it is not re-decoded.
            cmd_err_next = 1'b1;
            state_next   = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (tmo_expire) begin
      cmd_err_next = 1'b1;
      state_next   = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      mode_reg        <= MODE_RST;
      freq_word_reg   <= FREQ_DEFAULT;
      freq_update_reg <= 1'b0;
      cmd_err_reg     <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      mode_reg        <= mode_next;
      freq_word_reg   <= freq_word_next;
      freq_update_reg <= freq_update_next;
      cmd_err_reg     <= cmd_err_next;
      busy_reg        <= (state_next == FREQ);
    end
  end

  assign mode        = mode_reg;
  assign freq_word   = freq_word_reg;
  assign freq_update = freq_update_reg;
  assign cmd_err     = cmd_err_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_decoder
// Scoreboard bench: every byte driven is run through an integer-level
// reference model and the expected post-byte outputs are queued; a monitor
// pops one entry for each strobe the DUT consumed and compares all outputs.
// ---------------------------------------------------------------------------
module tb_uart_cmd_decoder;

  localparam int NM = 2;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic [NM-1:0] mode;
  logic [FW-1:0] freq_word;
  logic          freq_update;
  logic          cmd_err;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  typedef struct {
    logic [7:0]    b;
    logic          upd;
    logic          err;
    logic [NM-1:0] mode;
    logic [FW-1:0] fw;
    logic          busy;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  int m_mode;
  int m_fw;
  bit m_in_freq;
  int m_acc;
  int m_cnt;

  uart_cmd_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .mode        (mode),
    .freq_word   (freq_word),
    .freq_update (freq_update),
    .cmd_err     (cmd_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_mode    = 1;
    m_fw      = 1000;
    m_in_freq = 0;
    m_acc     = 0;
    m_cnt     = 0;
  endtask

  task automatic model_step(input logic [7:0] b);
    exp_t e;
    int   d;
    int   nv;
    e.upd = 1'b0;
    e.err = 1'b0;
    d = int'(b);
    if (d == 10) begin
      // LF: no effect anywhere
    end else if (!m_in_freq) begin
      if (d >= 65 && d < 65 + NM) m_mode = 1 << (d - 65);
      else if (d == 70) begin
        m_in_freq = 1;
        m_acc     = 0;
        m_cnt     = 0;
      end
    end else if (d >= 48 && d <= 57) begin
      nv = m_acc * 10 + (d - 48);
      if (nv > 65535 || m_cnt + 1 > 5) begin
        e.err     = 1'b1;
        m_in_freq = 0;
      end else begin
        m_acc = nv;
        m_cnt = m_cnt + 1;
      end
    end else if (d == 13) begin
      if (m_cnt >= 1) begin
        m_fw  = m_acc;
        e.upd = 1'b1;
      end else begin
        e.err = 1'b1;
      end
      m_in_freq = 0;
    end else begin
      e.err     = 1'b1;
      m_in_freq = 0;
    end
    e.b    = b;
    e.mode = NM'(m_mode);
    e.fw   = FW'(m_fw);
    e.busy = m_in_freq;
    exp_q.push_back(e);
  endtask

  // Present one byte for exactly one sampling edge.
  task automatic drive(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    model_step(b);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_str(input string s);
    for (int i = 0; i < s.len(); i++) drive(s[i]);
  endtask

  task automatic gap();
    int n;
    n = int'($urandom_range(0, 4));
    if (n > 2) n = 0;
    if (n > 0) idle(n);
  endtask

  // Monitor: a strobe seen at a rising edge yields an output one edge later;
  // checked at the falling edge.
  initial begin : monitor
    bit   v;
    exp_t e;
    forever begin
      @(posedge clk);
      v = (rx_valid === 1'b1) && (rst_n === 1'b1);
      @(negedge clk);
      if (v && rst_n === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("queue_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          txn++;
          $display("txn %0d byte=%02h upd=%b err=%b mode=%b fw=%0d busy=%b", txn,
                   e.b, freq_update, cmd_err, mode, freq_word, busy);
          chk("freq_update", int'(freq_update), int'(e.upd));
          chk("cmd_err", int'(cmd_err), int'(e.err));
          chk("mode", int'(mode), int'(e.mode));
          chk("freq_word", int'(freq_word), int'(e.fw));
          chk("busy", int'(busy), int'(e.busy));
        end
      end else if (rst_n === 1'b1) begin
        chk("no_spurious_pulse", int'({freq_update, cmd_err}), 0);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_mode"}, int'(mode), 1);
    chk({tag, "_freq_word"}, int'(freq_word), 1000);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_pulses"}, int'({freq_update, cmd_err}), 0);
  endtask

  initial begin : stim
    int    val;
    int    r;
    string s;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    idle(2);

    // directed
    drive("B");
    drive_str("F440"); drive(8'h0D);
    idle(2);
    drive_str("F70000"); drive(8'h0D);
    idle(1);
    drive_str("F1A"); drive(8'h0D);
    drive("F"); drive(8'h0D);
    drive("Z"); drive(8'h0A);
    drive_str("F65535"); drive(8'h0D);
    drive_str("F65536"); drive(8'h0D);
    drive_str("F000001"); drive(8'h0D);
    drive_str("F00009"); drive(8'h0D);
    drive_str("F1"); drive(8'h0A); drive("2"); drive(8'h0D);
    drive_str("F3F"); drive("A");
    idle(2);

    // reset in the middle of a command
    drive_str("F12");
    rx_valid = 1'b0;
    #6;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // randomized traffic
    for (int it = 0; it < 250; it++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5) begin
        val = int'($urandom_range(0, 70000));
        s = $sformatf("%0d", val);
        if ($urandom_range(0, 4) == 0) s = {"0", s};
        drive("F");
        gap();
        for (int i = 0; i < s.len(); i++) begin
          drive(s[i]);
          gap();
        end
        case ($urandom_range(0, 9))
          0:       drive(8'($urandom));
          1:       begin drive(8'h0A); drive(8'h0D); end
          default: drive(8'h0D);
        endcase
      end else if (r < 7) begin
        drive(8'(8'h41 + $urandom_range(0, 4)));
      end else if (r == 7) begin
        drive(8'h0A);
      end else begin
        drive(8'($urandom));
      end
      gap();
    end

    idle(4);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
